// File: rtl/mult_pipe_reg.sv
// mult_pipe_reg: register pipeline that carries multiplier results and their
// writeback metadata from mult1 to the writeback arbiter.
// Each stage has a valid bit. Back-pressure collapses bubbles, flush kills
// every in-flight entry, and the block reports its occupancy.
// Optional: define MULT_PIPE_HAZARD_EN to expose in-flight destination hazard
// outputs for rs1/rs2.
module mult_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [ADDR_W-1:0] in_addr_i,
    input  logic              in_we_i,
    input  logic [DATA_W-1:0] in_instr_i,
    input  logic [DATA_W-1:0] in_pc_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic              out_we_o,
    output logic [DATA_W-1:0] out_instr_o,
    output logic [DATA_W-1:0] out_pc_o,
    output logic [STAGES-1:0] stage_valid_o,
    output logic [3:0]        count_o
`ifdef MULT_PIPE_HAZARD_EN
    ,
    input  logic [ADDR_W-1:0] rs1_addr_i,
    input  logic [ADDR_W-1:0] rs2_addr_i,
    output logic              hazard_rs1_o,
    output logic              hazard_rs2_o
`endif
);

    logic [STAGES-1:0]             valid_q, valid_d, ready;
    logic [STAGES-1:0]             we_q, we_d;
    logic [STAGES-1:0][DATA_W-1:0] data_q, data_d;
    logic [STAGES-1:0][DATA_W-1:0] instr_q, instr_d;
    logic [STAGES-1:0][DATA_W-1:0] pc_q, pc_d;
    logic [STAGES-1:0][ADDR_W-1:0] addr_q, addr_d;

    // Ready chain. A stage is blocked only if it and every stage after it are
    // valid while the output is stalled. Folding the chain this way avoids a
    // self-referencing combinational vector.
    always_comb begin
        logic tail_blocked;
        tail_blocked = stall_i;
        ready        = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            tail_blocked = tail_blocked && valid_q[k];
            ready[k]     = !tail_blocked;
        end
    end

    assign in_ready_o = ready[0];

    // Next state: each ready stage pulls from its source. Payload moves only
    // with a valid source, so bubbles leave stale data behind. Flush clears
    // the valid bits and leaves the payload untouched.
    always_comb begin
        valid_d = valid_q;
        we_d    = we_q;
        data_d  = data_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        if (ready[0]) begin
            valid_d[0] = in_valid_i;
            if (in_valid_i) begin
                data_d[0]  = in_data_i;
                addr_d[0]  = in_addr_i;
                we_d[0]    = in_we_i;
                instr_d[0] = in_instr_i;
                pc_d[0]    = in_pc_i;
            end
        end
        for (int k = 1; k < STAGES; k++) begin
            if (ready[k]) begin
                valid_d[k] = valid_q[k-1];
                if (valid_q[k-1]) begin
                    data_d[k]  = data_q[k-1];
                    addr_d[k]  = addr_q[k-1];
                    we_d[k]    = we_q[k-1];
                    instr_d[k] = instr_q[k-1];
                    pc_d[k]    = pc_q[k-1];
                end
            end
        end
        if (flush_i) begin
            valid_d = '0;
            we_d    = we_q;
            data_d  = data_q;
            instr_d = instr_q;
            pc_d    = pc_q;
            addr_d  = addr_q;
        end
    end

    // State registers. The async reset clears valid bits and payload.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            we_q    <= '0;
            data_q  <= '0;
            instr_q <= '0;
            pc_q    <= '0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            we_q    <= we_d;
            data_q  <= data_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
        end
    end

    assign out_valid_o   = valid_q[STAGES-1];
    assign out_data_o    = data_q[STAGES-1];
    assign out_addr_o    = addr_q[STAGES-1];
    assign out_we_o      = valid_q[STAGES-1] && we_q[STAGES-1];
    assign out_instr_o   = instr_q[STAGES-1];
    assign out_pc_o      = pc_q[STAGES-1];
    assign stage_valid_o = valid_q;

    // Occupancy: the popcount of the current valid bits.
    always_comb begin
        count_o = '0;
        for (int k = 0; k < STAGES; k++) count_o = count_o + 4'(valid_q[k]);
    end

`ifdef MULT_PIPE_HAZARD_EN
    // Hazard: a valid, writing in-flight entry targets a source register.
    // Register x0 never counts as a hazard.
    always_comb begin
        hazard_rs1_o = 1'b0;
        hazard_rs2_o = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            if (valid_q[k] && we_q[k] && addr_q[k] == rs1_addr_i && rs1_addr_i != '0)
                hazard_rs1_o = 1'b1;
            if (valid_q[k] && we_q[k] && addr_q[k] == rs2_addr_i && rs2_addr_i != '0)
                hazard_rs2_o = 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mult_pipe_reg.sv
// tb_mult_pipe_reg: scoreboard bench for mult_pipe_reg with STAGES=3.
// Hazard checks are compiled in only when MULT_PIPE_HAZARD_EN is defined.
module tb_mult_pipe_reg;
    localparam int DW = 32, AW = 5, ST = 3;

    logic          clk_i = 1'b0, rst_i;
    logic          in_valid_i, in_ready_o, in_we_i, stall_i, flush_i;
    logic [DW-1:0] in_data_i, in_instr_i, in_pc_i;
    logic [AW-1:0] in_addr_i;
    logic          out_valid_o, out_we_o;
    logic [DW-1:0] out_data_o, out_instr_o, out_pc_o;
    logic [AW-1:0] out_addr_o;
    logic [ST-1:0] stage_valid_o;
    logic [3:0]    count_o;
`ifdef MULT_PIPE_HAZARD_EN
    logic [AW-1:0] rs1_addr_i, rs2_addr_i;
    logic          hazard_rs1_o, hazard_rs2_o;
`endif

    int checks = 0, failures = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] instr;
        logic [DW-1:0] pc;
    } ent_t;
    ent_t sb[$];

    mult_pipe_reg #(.DATA_W(DW), .ADDR_W(AW), .STAGES(ST)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_data_i(in_data_i), .in_addr_i(in_addr_i), .in_we_i(in_we_i),
        .in_instr_i(in_instr_i), .in_pc_i(in_pc_i),
        .stall_i(stall_i), .flush_i(flush_i),
        .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_addr_o(out_addr_o),
        .out_we_o(out_we_o), .out_instr_o(out_instr_o), .out_pc_o(out_pc_o),
        .stage_valid_o(stage_valid_o), .count_o(count_o)
`ifdef MULT_PIPE_HAZARD_EN
        , .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .hazard_rs1_o(hazard_rs1_o), .hazard_rs2_o(hazard_rs2_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Scoreboard monitor. It samples on the falling edge, where the inputs and
    // outputs are stable, and predicts the handshakes at the next rising edge.
    always @(negedge clk_i) begin
        if (rst_i || flush_i) begin
            sb.delete();
        end else begin
            if (out_valid_o && !stall_i) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_underflow got data=%h, expected no output", out_data_o);
                end else begin
                    ent_t e;
                    e = sb.pop_front();
                    if (out_data_o !== e.data || out_addr_o !== e.addr || out_we_o !== e.we ||
                        out_instr_o !== e.instr || out_pc_o !== e.pc) begin
                        failures++;
                        $display("FAIL sb_entry got d=%h a=%0d we=%b i=%h pc=%h exp d=%h a=%0d we=%b i=%h pc=%h",
                                 out_data_o, out_addr_o, out_we_o, out_instr_o, out_pc_o,
                                 e.data, e.addr, e.we, e.instr, e.pc);
                    end
                end
            end
            if (in_valid_i && in_ready_o)
                sb.push_back('{in_data_i, in_addr_i, in_we_i, in_instr_i, in_pc_i});
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic put(input logic v, input logic [DW-1:0] d, input logic [AW-1:0] a, input logic w);
        in_valid_i = v;
        in_data_i  = d;
        in_addr_i  = a;
        in_we_i    = w;
        in_instr_i = d ^ 32'hA5A5_0000;
        in_pc_i    = 32'h0000_1000 + {d[29:0], 2'b00};
    endtask

    task automatic test_reset();
        checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL rst_out_valid got %b exp 0", out_valid_o); end
        checks++; if (out_we_o !== 1'b0) begin failures++; $display("FAIL rst_out_we got %b exp 0", out_we_o); end
        checks++; if (count_o !== 4'd0) begin failures++; $display("FAIL rst_count got %0d exp 0", count_o); end
        checks++; if (stage_valid_o !== 3'b000) begin failures++; $display("FAIL rst_stage_valid got %b exp 000", stage_valid_o); end
        checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL rst_in_ready got %b exp 1", in_ready_o); end
        checks++; if ({out_data_o, out_addr_o, out_instr_o, out_pc_o} !== '0) begin failures++; $display("FAIL rst_payload got d=%h a=%0d i=%h pc=%h exp 0", out_data_o, out_addr_o, out_instr_o, out_pc_o); end
    endtask

    task automatic test_reset_midstream();
        put(1, 32'hAA, 5'd3, 1); tick();
        put(1, 32'hBB, 5'd4, 1); tick();
        put(0, 0, 0, 0);
        checks++; if (count_o !== 4'd2) begin failures++; $display("FAIL mid_count_pre got %0d exp 2", count_o); end
        #2 rst_i = 1'b1;
        #1;
        checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL mid_out_valid got %b exp 0", out_valid_o); end
        checks++; if (count_o !== 4'd0) begin failures++; $display("FAIL mid_count got %0d exp 0", count_o); end
        checks++; if (out_data_o !== 32'h0) begin failures++; $display("FAIL mid_out_data got %h exp 0", out_data_o); end
        checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL mid_in_ready got %b exp 1", in_ready_o); end
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_streaming();
        put(1, 32'h11, 5'd5, 1); tick();
        put(1, 32'h22, 5'd5, 1); tick();
        put(1, 32'h33, 5'd5, 1); tick();
        put(0, 0, 0, 0);
        checks++; if (out_valid_o !== 1'b1 || out_data_o !== 32'h11 || out_we_o !== 1'b1) begin failures++; $display("FAIL stream_e3 got v=%b d=%h we=%b exp v=1 d=11 we=1", out_valid_o, out_data_o, out_we_o); end
        checks++; if (count_o !== 4'd3) begin failures++; $display("FAIL stream_peak got %0d exp 3", count_o); end
        tick();
        checks++; if (out_data_o !== 32'h22 || out_we_o !== 1'b1 || count_o !== 4'd2) begin failures++; $display("FAIL stream_e4 got d=%h we=%b cnt=%0d exp d=22 we=1 cnt=2", out_data_o, out_we_o, count_o); end
        tick();
        checks++; if (out_data_o !== 32'h33 || out_we_o !== 1'b1 || count_o !== 4'd1) begin failures++; $display("FAIL stream_e5 got d=%h we=%b cnt=%0d exp d=33 we=1 cnt=1", out_data_o, out_we_o, count_o); end
        tick();
        checks++; if (out_valid_o !== 1'b0 || out_we_o !== 1'b0 || count_o !== 4'd0) begin failures++; $display("FAIL stream_drain got v=%b we=%b cnt=%0d exp 0/0/0", out_valid_o, out_we_o, count_o); end
        checks++; if (out_data_o !== 32'h33) begin failures++; $display("FAIL stream_stale got %h exp 33", out_data_o); end
    endtask

    task automatic test_bubble_collapse();
        put(1, 32'hA1, 5'd1, 1); tick();
        put(0, 0, 0, 0);         tick();
        put(1, 32'hB2, 5'd2, 0); tick();
        stall_i = 1'b1;
        put(0, 0, 0, 0);         tick();
        checks++; if (count_o !== 4'd2 || stage_valid_o !== 3'b110) begin failures++; $display("FAIL bub_two got cnt=%0d sv=%b exp 2/110", count_o, stage_valid_o); end
        checks++; if (in_ready_o !== 1'b1 || out_data_o !== 32'hA1 || out_valid_o !== 1'b1) begin failures++; $display("FAIL bub_hold1 got rdy=%b d=%h v=%b exp 1/a1/1", in_ready_o, out_data_o, out_valid_o); end
        put(1, 32'hC3, 5'd3, 1); tick();
        put(1, 32'hD4, 5'd4, 1);
        checks++; if (count_o !== 4'd3 || stage_valid_o !== 3'b111) begin failures++; $display("FAIL bub_full got cnt=%0d sv=%b exp 3/111", count_o, stage_valid_o); end
        checks++; if (in_ready_o !== 1'b0 || out_data_o !== 32'hA1) begin failures++; $display("FAIL bub_hold2 got rdy=%b d=%h exp 0/a1", in_ready_o, out_data_o); end
        tick();
        put(0, 0, 0, 0);
        checks++; if (count_o !== 4'd3 || out_data_o !== 32'hA1 || out_we_o !== 1'b1) begin failures++; $display("FAIL bub_hold3 got cnt=%0d d=%h we=%b exp 3/a1/1", count_o, out_data_o, out_we_o); end
    endtask

    task automatic test_stall_release();
        stall_i = 1'b0;
        #1;
        checks++; if (in_ready_o !== 1'b1 || out_data_o !== 32'hA1) begin failures++; $display("FAIL rel_first got rdy=%b d=%h exp 1/a1", in_ready_o, out_data_o); end
        tick();
        checks++; if (out_data_o !== 32'hB2 || out_we_o !== 1'b0 || count_o !== 4'd2) begin failures++; $display("FAIL rel_b got d=%h we=%b cnt=%0d exp b2/0/2", out_data_o, out_we_o, count_o); end
        tick();
        checks++; if (out_data_o !== 32'hC3 || out_we_o !== 1'b1 || count_o !== 4'd1) begin failures++; $display("FAIL rel_c got d=%h we=%b cnt=%0d exp c3/1/1", out_data_o, out_we_o, count_o); end
        tick();
        checks++; if (out_valid_o !== 1'b0 || count_o !== 4'd0) begin failures++; $display("FAIL rel_empty got v=%b cnt=%0d exp 0/0", out_valid_o, count_o); end
    endtask

    task automatic test_flush();
        stall_i = 1'b1;
        put(1, 32'hE1, 5'd6, 1); tick();
        put(1, 32'hE2, 5'd6, 1); tick();
        put(1, 32'hE3, 5'd6, 1); tick();
        checks++; if (count_o !== 4'd3) begin failures++; $display("FAIL fl_full got %0d exp 3", count_o); end
        put(1, 32'hF0, 5'd9, 1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        put(0, 0, 0, 0);
        checks++; if (count_o !== 4'd0 || stage_valid_o !== 3'b000 || out_valid_o !== 1'b0 || out_we_o !== 1'b0) begin failures++; $display("FAIL fl_clear got cnt=%0d sv=%b v=%b we=%b exp 0", count_o, stage_valid_o, out_valid_o, out_we_o); end
        checks++; if (in_ready_o !== 1'b1 || out_data_o !== 32'hE1) begin failures++; $display("FAIL fl_payload got rdy=%b d=%h exp 1/e1", in_ready_o, out_data_o); end
        tick();
        checks++; if (count_o !== 4'd0 || out_valid_o !== 1'b0) begin failures++; $display("FAIL fl_nocapture got cnt=%0d v=%b exp 0/0", count_o, out_valid_o); end
        stall_i = 1'b0;
        put(1, 32'h77, 5'd8, 1); tick();
        put(0, 0, 0, 0);         tick(); tick();
        checks++; if (out_valid_o !== 1'b1 || out_data_o !== 32'h77) begin failures++; $display("FAIL fl_after got v=%b d=%h exp 1/77", out_valid_o, out_data_o); end
        tick();
    endtask

`ifdef MULT_PIPE_HAZARD_EN
    task automatic test_hazard();
        stall_i = 1'b1;
        rs1_addr_i = 5'd7;
        rs2_addr_i = 5'd0;
        put(1, 32'h99, 5'd7, 1); tick();
        put(0, 0, 0, 0);
        checks++; if (hazard_rs1_o !== 1'b1 || hazard_rs2_o !== 1'b0) begin failures++; $display("FAIL hz_we1 got rs1=%b rs2=%b exp 1/0", hazard_rs1_o, hazard_rs2_o); end
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        put(1, 32'h9A, 5'd7, 0); tick();
        put(0, 0, 0, 0);
        checks++; if (hazard_rs1_o !== 1'b0) begin failures++; $display("FAIL hz_we0 got %b exp 0", hazard_rs1_o); end
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        stall_i = 1'b0;
    endtask
`endif

    initial begin
        rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        put(0, 0, 0, 0);
`ifdef MULT_PIPE_HAZARD_EN
        rs1_addr_i = '0; rs2_addr_i = '0;
`endif
        #3;
        test_reset();
        tick();
        rst_i = 1'b0;
        test_reset_midstream();
        test_streaming();
        test_bubble_collapse();
        test_stall_release();
        test_flush();
`ifdef MULT_PIPE_HAZARD_EN
        test_hazard();
`endif
        tick();
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL sb_leftover got %0d entries exp 0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mult_pipe_reg.md
Name: mult_pipe_reg

Overview:
Parametrised register pipeline that carries multiplier results and their writeback metadata (data, destination register, write enable, instruction, PC) from mult1 through STAGES register stages to the writeback side.
- Adds per-stage valid bits, back-pressure with bubble collapsing, flush, occupancy count, and in-flight destination visibility for hazard logic.
- Sits between the multiplier front stage and the register-file writeback arbiter.

Parameters:
DATA_W, 32, width of write data, instruction and PC fields
ADDR_W, 5, destination register address width
STAGES, 2, number of register stages (legal range 1..8)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  asynchronous, active-high reset
in_valid_i  in  1  upstream entry valid
in_ready_o  out  1  pipeline can accept an entry this cycle
in_data_i  in  DATA_W  multiplier write data
in_addr_i  in  ADDR_W  destination register
in_we_i  in  1  integer write enable
in_instr_i  in  DATA_W  instruction word
in_pc_i  in  DATA_W  instruction PC
stall_i  in  1  downstream cannot accept output this cycle
flush_i  in  1  kill all in-flight entries
out_valid_o  out  1  last stage holds a valid entry
out_data_o  out  DATA_W  last-stage data
out_addr_o  out  ADDR_W  last-stage destination
out_we_o  out  1  last-stage write enable, gated by out_valid_o
out_instr_o  out  DATA_W  last-stage instruction
out_pc_o  out  DATA_W  last-stage PC
stage_valid_o  out  STAGES  valid bit per stage, bit 0 = first stage
count_o  out  4  number of valid stages (0..STAGES)

Behaviour:
- Reset (async, rst_i=1): all valid bits 0; all payload registers 0. Outputs read out_valid_o=0, out_we_o=0, all data/addr/instr/pc outputs 0, stage_valid_o=0, count_o=0. in_ready_o=1 during and after reset.
- Stage ready chain:
  - ready[STAGES-1] = !valid[STAGES-1] || !stall_i.
  - ready[k] = !valid[k] || ready[k+1].
  - in_ready_o = ready[0] (combinational).
- Stage advance: stage k loads from stage k-1 (stage 0 loads from inputs) when ready[k].
  - The loaded valid bit is the source's valid bit; stage 0 loads in_valid_i.
  - Otherwise stage k holds.
  - A valid entry whose stage loads and is not refilled becomes invalid (bubble).
- Payload is loaded only when the incoming valid bit is 1. When the incoming valid bit is 0, only the valid bit clears and the payload holds its stale value.
- Latency: with stall_i=0, an entry accepted at edge n appears on the out_* ports after edge n+STAGES-1. Throughput is one entry per cycle.
- Bubble collapse: while stall_i=1 and the last stage is valid, upstream entries continue advancing into empty stages. in_ready_o drops only when all STAGES stages are valid.
- Output handshake: an entry leaves when out_valid_o && !stall_i. Output fields hold stable while out_valid_o && stall_i.
- out_we_o = valid[STAGES-1] && we[STAGES-1]; never 1 while out_valid_o=0.
- Flush: flush_i=1 at an edge clears every valid bit and ignores in_valid_i that cycle. Flush wins over stall and load when they occur together. Payload registers are not cleared.
- count_o = popcount of the valid bits, registered-equivalent (reflects current state), zero-extended to 4 bits.
- STAGES=1: single register; in_ready_o = !out_valid_o || !stall_i.

Optional Feature:
MULT_PIPE_HAZARD_EN
- Defined: adds inputs rs1_addr_i and rs2_addr_i (ADDR_W each) and outputs hazard_rs1_o and hazard_rs2_o (1 each).
  - hazard_rsN_o = 1 when any stage k has valid[k] && we[k] && addr[k]==rsN_addr_i && rsN_addr_i!=0.
  - Purely combinational from current state. Reset value 0.
- Not defined: these ports and their logic are absent. Core behaviour is unchanged.

Test Plan:
- Reset mid-stream: with STAGES=2, load 2 entries, assert rst_i asynchronously between edges -> out_valid_o=0, count_o=0, out_data_o=0 immediately; in_ready_o=1.
- Streaming: STAGES=3, stall_i=0, feed data 0x11,0x22,0x33 on consecutive cycles with in_we_i=1, addr=5 -> out_data_o shows 0x11,0x22,0x33 on edges 3,4,5; out_we_o=1 each; count_o peaks at 3.
- Bubble collapse: STAGES=3, entries A, bubble, B; then hold stall_i=1 -> B advances until stages full (count_o=2 then accepts C, count_o=3, in_ready_o=0); out_data_o holds A throughout.
- Stall release: from the full state above, drop stall_i -> A, B, C drain one per cycle; in_ready_o=1 on the first released cycle; no entry duplicated or lost.
- Flush priority: full pipe, stall_i=1, flush_i=1, in_valid_i=1 on the same edge -> all valid=0, count_o=0, out_we_o=0, the new entry is not captured.
- Hazard (MULT_PIPE_HAZARD_EN): in-flight entry addr=7, we=1, rs1_addr_i=7, rs2_addr_i=0 -> hazard_rs1_o=1, hazard_rs2_o=0. Same entry with we=0 -> hazard_rs1_o=0.
